// File: rtl/clk_gen_tap_sel_ctrl.sv
// Tap-select controller for the tunable clock generator: holds the ring-oscillator
// tap index and moves it by direct jump or one-tap slew with a settle interval per step.
module clk_gen_tap_sel_ctrl #(
    parameter int SEL_W      = 4,
    parameter int SETTLE_CYC = 8,
    parameter int RESET_SEL  = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [(2**SEL_W)-1:0] taps_i,
    input  logic [SEL_W-1:0]      tgt_sel_i,
    input  logic                  tgt_mode_i,
    input  logic                  tgt_v_i,
    output logic                  tgt_ready_o,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  clk_o
);

    localparam int N     = 2**SEL_W;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [SEL_W-1:0] SEL_RST    = SEL_W'(RESET_SEL);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [N-1:0]     mux_cur_s;
    logic [N-1:0]     mux_nxt_s;

    // Move one tap toward the target; never wraps between 0 and N-1.
    function automatic logic [SEL_W-1:0] step_toward(input logic [SEL_W-1:0] cur,
                                                     input logic [SEL_W-1:0] tgt);
        logic [SEL_W-1:0] nxt;
        if (tgt > cur) begin
            nxt = cur + SEL_W'(1);
        end else if (tgt < cur) begin
            nxt = cur - SEL_W'(1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // State register with asynchronous reset to the power-on select.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_RST;
            tgt_q   <= SEL_RST;
            mode_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, count down and step in SETTLE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tgt_v_i) begin
                    tgt_d  = tgt_sel_i;
                    mode_d = tgt_mode_i;
                    if (tgt_sel_i == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        if (tgt_mode_i) begin
                            sel_d = step_toward(sel_q, tgt_sel_i);
                        end else begin
                            sel_d = tgt_sel_i;
                        end
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (sel_q == tgt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    // Only slew requests reach this point; a jump lands on target at accept.
                    if (mode_q) begin
                        sel_d = step_toward(sel_q, tgt_q);
                    end else begin
                        sel_d = tgt_q;
                    end
                    cnt_d = CNT_RELOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        tgt_ready_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tgt_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            ST_SETTLE: begin
                tgt_ready_o = 1'b0;
                busy_o      = 1'b1;
            end
            default: begin
                tgt_ready_o = 1'b0;
                busy_o      = 1'b0;
            end
        endcase
    end

    assign sel_o  = sel_q;
    assign done_o = done_q;

    // Non-inverting binary 2:1 mux tree, select LSB resolving the leaf pairs.
    always_comb begin
        mux_cur_s = taps_i;
        mux_nxt_s = {N{1'b0}};
        for (int d = 0; d < SEL_W; d++) begin
            mux_nxt_s = {N{1'b0}};
            for (int j = 0; j < N / 2; j++) begin
                if (sel_q[d]) begin
                    mux_nxt_s[j] = mux_cur_s[2*j+1];
                end else begin
                    mux_nxt_s[j] = mux_cur_s[2*j];
                end
            end
            mux_cur_s = mux_nxt_s;
        end
        clk_o = mux_cur_s[0];
    end

endmodule

// File: doc/clk_gen_tap_sel_ctrl.md
Name: clk_gen_tap_sel_ctrl

Overview:
Parametrised successor to the 16:1 inverting tap-select tree of the tunable clock generator. It selects one of 2^SEL_W ring-oscillator taps. The tap select is held in a register and changed only through a req/ready handshake. Two update modes are supported: direct jump, or slew of one tap at a time with a programmable settle interval between steps. It sits between the control/scan interface (clk_i domain) and the oscillator tap bus, and it drives the generated clock out.

Parameters:
SEL_W, 4, select width; number of taps N = 2^SEL_W (SEL_W >= 1).
SETTLE_CYC, 8, clk_i cycles held after every select change before the next step or completion (>= 1).
RESET_SEL, 0, select value loaded on reset (< N).

Ports:
clk_i  in  1  control clock; all state updates on rising edge.
reset_i  in  1  asynchronous, active-high reset.
taps_i  in  N  oscillator tap bus; tap k at bit k.
tgt_sel_i  in  SEL_W  requested tap index.
tgt_mode_i  in  1  0 = direct jump, 1 = slew one tap per step.
tgt_v_i  in  1  request valid.
tgt_ready_o  out  1  high only in IDLE; request accepted on an edge with tgt_v_i & tgt_ready_o.
sel_o  out  SEL_W  current registered tap select.
busy_o  out  1  high in SETTLE.
done_o  out  1  one-cycle pulse when a request completes.
clk_o  out  1  selected tap: taps_i[sel_o], non-inverted.

Behaviour:
- Reset (async, immediate): state=IDLE, sel_o=RESET_SEL, settle counter=0, latched target=RESET_SEL, done_o=0, busy_o=0. tgt_ready_o=1 after reset deasserts.
- clk_o is combinational from taps_i and sel_o. The tree structure is implementation choice; the overall path is non-inverting. sel_o changes only on clk_i edges and never by more than one tap per edge in slew mode.
- Settle counter width is $clog2(SETTLE_CYC+1).
- States: IDLE, SETTLE.
- IDLE, accept edge, tgt_sel_i == sel_o: stay IDLE. done_o=1 next cycle. sel_o is unchanged.
- IDLE, accept edge, tgt_sel_i != sel_o, direct mode: sel_o <= tgt_sel_i, counter <= SETTLE_CYC-1, go SETTLE.
- IDLE, accept edge, tgt_sel_i != sel_o, slew mode: sel_o <= sel_o+1 if the target is higher, else sel_o-1. Counter <= SETTLE_CYC-1, go SETTLE. Target and mode are latched.
- SETTLE, counter != 0: counter decrements.
- SETTLE, counter == 0 and sel_o == latched target: go IDLE, done_o=1 for one cycle.
- SETTLE, counter == 0 and sel_o != latched target (slew only): step sel_o by one tap toward the target, reload counter with SETTLE_CYC-1.
- Latency (accept edge ends cycle 0):
  - Equal target: done_o in cycle 1.
  - Direct: done_o in cycle SETTLE_CYC+1.
  - Slew, distance D: done_o in cycle D*SETTLE_CYC+1.
  - tgt_ready_o rises in the same cycle as done_o.
- No wrap-around: slew moves monotonically between sel_o and the target. 0 <-> N-1 takes N-1 steps, never 1.
- tgt_v_i while busy: ignored, not queued. The inputs are sampled only on the accept edge, so later changes to tgt_sel_i or tgt_mode_i have no effect.
- done_o and tgt_v_i in the same IDLE cycle: the new request is accepted normally.
- Reset mid-operation: abort immediately to the reset values. No done_o pulse is generated.
- SETTLE_CYC=1: every SETTLE cycle is a terminal cycle, so slew steps on consecutive edges.

Test Plan:
- Reset with SEL_W=4, SETTLE_CYC=8, RESET_SEL=0 -> sel_o=0, tgt_ready_o=1, busy_o=0, done_o=0; clk_o follows taps_i[0].
- Direct request to 11 from 0 -> sel_o=11 in cycle 1, busy_o high in cycles 1-8, done_o pulse in cycle 9, clk_o follows taps_i[11].
- Slew request 0->3 -> sel_o steps 1,2,3 in cycles 1, 9, 17; done_o in cycle 25; tgt_ready_o low in cycles 1-24.
- Slew request 15->0 -> 15 single downward steps, no transition 15->0; done_o in cycle 121. A tgt_v_i pulse with target 5 during busy is ignored and sel_o ends at 0.
- Request equal to the current select (sel_o=7, target 7) -> done_o in cycle 1, sel_o unchanged, busy_o never high. A request back-to-back in the done_o cycle is accepted.
- reset_i asserted mid-slew at sel_o=6 -> sel_o=0 immediately (async), state IDLE, no done_o. With SETTLE_CYC=1, slew 2->5 gives sel_o 3,4,5 in cycles 1-3 and done_o in cycle 4.
